// File: rtl/dyn_partition_pkg.sv
// Shared helpers for the dynamic-partition counter: Johnson phase encoding and width helpers.
// Johnson codes are carried in a MAX_PART-wide vector so the helpers work for any partition count.
package dyn_partition_pkg;

  localparam int MAX_PART     = 32;
  localparam int DEF_NUM_PART = 2;
  localparam int DEF_WIDTH    = 3;
  localparam int PHASES       = 2 * DEF_NUM_PART;

  typedef logic [MAX_PART-1:0] jcode_t;

  function automatic int phases_of(input int n);
    return 2 * n;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int nc_width(input int n);
    return $clog2(2 * n + 1);
  endfunction

  function automatic jcode_t low_mask(input int n);
    if (n >= MAX_PART) return '1;
    return (jcode_t'(1) << n) - jcode_t'(1);
  endfunction

  // Shift left, feeding the inverted top bit of an n-bit code into bit 0.
  function automatic jcode_t johnson_next(input jcode_t j, input int n);
    jcode_t     nxt;
    logic [4:0] top_idx;
    top_idx = 5'(n - 1);
    nxt     = (j << 1) & low_mask(n);
    nxt[0]  = ~j[top_idx];
    return nxt;
  endfunction

  // Steps from the all-zero code: filling phase counts ones, draining phase counts down from 2n.
  function automatic int johnson_to_index(input jcode_t j, input int n);
    int ones;
    ones = $countones(j);
    if (j[0] || (j == '0)) return ones;
    return 2 * n - ones;
  endfunction

  function automatic jcode_t johnson_of(input int k, input int n);
    if (k <= n) return low_mask(k);
    return low_mask(n) & ~low_mask(k - n);
  endfunction

endpackage

// File: rtl/dyn_partition_phase.sv
// Johnson phase register with combinational decode of the active partition index.
// Optional DYN_PART_TRACE_EN adds a legality check on the phase code.
module dyn_partition_phase
  import dyn_partition_pkg::*;
#(
  parameter int NUM_PART = DEF_NUM_PART
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        adv,
  output logic [NUM_PART-1:0]         johnson,
  output logic [$clog2(NUM_PART)-1:0] active_idx
);

  localparam int IDX_W = $clog2(NUM_PART);

  logic [NUM_PART-1:0] johnson_q;
  int                  phase_k;

  always_ff @(posedge clk) begin
    if (rst) begin
      johnson_q <= '0;
    end else if (adv) begin
      johnson_q <= NUM_PART'(johnson_next(jcode_t'(johnson_q), NUM_PART));
    end
  end

  always_comb begin
    phase_k    = johnson_to_index(jcode_t'(johnson_q), NUM_PART);
    active_idx = IDX_W'(phase_k % NUM_PART);
  end

  assign johnson = johnson_q;

`ifdef DYN_PART_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ((int'(active_idx) < NUM_PART) &&
              (NUM_PART'(johnson_of(phase_k, NUM_PART)) == johnson_q))
        else $error("dyn_partition_phase: illegal phase code %b", johnson_q);
    end
  end
`endif

endmodule

// File: rtl/dyn_partition_counter.sv
// NUM_PART counters advanced one at a time in Johnson phase order, with wrap/saturate and fixpoint detect.
// Optional DYN_PART_TRACE_EN adds a 32-bit accepted-step counter output step_cnt.
module dyn_partition_counter
  import dyn_partition_pkg::*;
#(
  parameter int NUM_PART = DEF_NUM_PART,
  parameter int WIDTH    = DEF_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        step_valid,
  output logic                        step_ready,
  input  logic                        mode_sat,
  output logic [NUM_PART*WIDTH-1:0]   cnt_flat,
  output logic [NUM_PART-1:0]         johnson,
  output logic [$clog2(NUM_PART)-1:0] active_idx,
  output logic [NUM_PART-1:0]         wrap_pulse,
  output logic                        fixpoint
`ifdef DYN_PART_TRACE_EN
  ,
  output logic [31:0]                 step_cnt
`endif
);

  localparam int NC_W = nc_width(NUM_PART);
  localparam int PH   = phases_of(NUM_PART);

  // Handshake: a step is taken on any rising edge where step_valid && step_ready and rst is low;
  // step_ready drops permanently once the fixpoint is reached and only rst restores it.
  logic                acc;
  logic [WIDTH-1:0]    cnt_q [NUM_PART];
  logic [WIDTH-1:0]    cur;
  logic                all_ones;
  logic                cnt_changes;
  logic                wrap_hit;
  logic [NC_W-1:0]     nc_q;
  logic                fix_q;
  logic [NUM_PART-1:0] wrap_q;

  assign step_ready = ~fix_q;
  assign acc        = step_valid & step_ready;

  dyn_partition_phase #(.NUM_PART(NUM_PART)) u_phase (
    .clk        (clk),
    .rst        (rst),
    .adv        (acc),
    .johnson    (johnson),
    .active_idx (active_idx)
  );

  always_comb begin
    cur         = cnt_q[active_idx];
    all_ones    = &cur;
    cnt_changes = ~(mode_sat & all_ones);
    wrap_hit    = ~mode_sat & all_ones;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_PART; p++) cnt_q[p] <= '0;
      nc_q   <= '0;
      fix_q  <= 1'b0;
      wrap_q <= '0;
    end else begin
      wrap_q <= '0;
      if (acc) begin
        if (cnt_changes) begin
          cnt_q[active_idx] <= cur + WIDTH'(1);
          nc_q              <= '0;
        end else begin
          nc_q <= nc_q + NC_W'(1);
          // A full phase period without any counter moving means no partition can move again.
          if ((nc_q + NC_W'(1)) == NC_W'(PH)) fix_q <= 1'b1;
        end
        if (wrap_hit) wrap_q[active_idx] <= 1'b1;
      end
    end
  end

  for (genvar p = 0; p < NUM_PART; p++) begin : g_flat
    assign cnt_flat[p*WIDTH +: WIDTH] = cnt_q[p];
  end

  assign wrap_pulse = wrap_q;
  assign fixpoint   = fix_q;

`ifdef DYN_PART_TRACE_EN
  logic [31:0] step_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)      step_cnt_q <= '0;
    else if (acc) step_cnt_q <= step_cnt_q + 32'd1;
  end

  assign step_cnt = step_cnt_q;
`endif

endmodule

// File: tb/tb_dyn_partition_counter.sv
// Directed bench for dyn_partition_counter at NUM_PART=2, WIDTH=3 with hand-computed expectations.
// Defining DYN_PART_TRACE_EN also connects and checks step_cnt.
module tb_dyn_partition_counter;

  logic       clk;
  logic       rst;
  logic       step_valid;
  logic       step_ready;
  logic       mode_sat;
  logic [5:0] cnt_flat;
  logic [1:0] johnson;
  logic [0:0] active_idx;
  logic [1:0] wrap_pulse;
  logic       fixpoint;
`ifdef DYN_PART_TRACE_EN
  logic [31:0] step_cnt;
`endif

  int n_cmp;
  int n_err;
  logic [31:0] exp_q[$];

  dyn_partition_counter #(.NUM_PART(2), .WIDTH(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .step_valid (step_valid),
    .step_ready (step_ready),
    .mode_sat   (mode_sat),
    .cnt_flat   (cnt_flat),
    .johnson    (johnson),
    .active_idx (active_idx),
    .wrap_pulse (wrap_pulse),
    .fixpoint   (fixpoint)
`ifdef DYN_PART_TRACE_EN
    ,
    .step_cnt   (step_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge, outputs are read there too
  task automatic do_reset();
    rst        = 1'b1;
    step_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic cycle(input logic v);
    step_valid = v;
    @(posedge clk);
    #1;
    step_valid = 1'b0;
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b1;
    step_valid = 1'b0;
    mode_sat   = 1'b0;

    // reset state
    do_reset();
    check("reset_cnt", 32'(cnt_flat), 32'h00);
    check("reset_johnson", 32'(johnson), 32'h0);
    check("reset_wrap", 32'(wrap_pulse), 32'h0);
    check("reset_fixpoint", 32'(fixpoint), 32'h0);
    check("reset_ready", 32'(step_ready), 32'h1);
    check("reset_active", 32'(active_idx), 32'h0);
`ifdef DYN_PART_TRACE_EN
    check("reset_step_cnt", step_cnt, 32'd0);
`endif

    // basic stepping: 4 steps alternate partitions 0,1,0,1
    cycle(1'b1);
    check("basic_s1_cnt", 32'(cnt_flat), 32'h01);
    check("basic_s1_johnson", 32'(johnson), 32'h1);
    check("basic_s1_active", 32'(active_idx), 32'h1);
    cycle(1'b1);
    check("basic_s2_johnson", 32'(johnson), 32'h3);
    cycle(1'b1);
    check("basic_s3_johnson", 32'(johnson), 32'h2);
    check("basic_s3_active", 32'(active_idx), 32'h1);
    check("basic_s3_wrap", 32'(wrap_pulse), 32'h0);
    cycle(1'b1);
    check("basic_cnt", 32'(cnt_flat), 32'h12);
    check("basic_johnson", 32'(johnson), 32'h0);
    check("basic_wrap", 32'(wrap_pulse), 32'h0);
`ifdef DYN_PART_TRACE_EN
    check("basic_step_cnt", step_cnt, 32'd4);
`endif

    // wrap mode: partition 0 wraps on step 15, partition 1 on step 16
    do_reset();
    mode_sat = 1'b0;
    for (int i = 1; i <= 16; i++) exp_q.push_back((i == 15) ? 32'h1 : (i == 16) ? 32'h2 : 32'h0);
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1);
      check($sformatf("wrap_pulse_s%0d", i), 32'(wrap_pulse), exp_q.pop_front());
    end
    check("wrap_final_cnt", 32'(cnt_flat), 32'h00);
    check("wrap_final_fixpoint", 32'(fixpoint), 32'h0);
    cycle(1'b0);
    check("wrap_pulse_cleared", 32'(wrap_pulse), 32'h0);

    // saturate and fixpoint
    do_reset();
    mode_sat = 1'b1;
    for (int i = 1; i <= 14; i++) cycle(1'b1);
    check("sat_cnt_77", 32'(cnt_flat), 32'h3f);
    check("sat_fixpoint_pre", 32'(fixpoint), 32'h0);
    for (int i = 15; i <= 17; i++) begin
      cycle(1'b1);
      check($sformatf("sat_hold_cnt_s%0d", i), 32'(cnt_flat), 32'h3f);
      check($sformatf("sat_nofix_s%0d", i), 32'(fixpoint), 32'h0);
      check($sformatf("sat_nowrap_s%0d", i), 32'(wrap_pulse), 32'h0);
    end
    cycle(1'b1);
    check("sat_fixpoint", 32'(fixpoint), 32'h1);
    check("sat_ready_low", 32'(step_ready), 32'h0);
    check("sat_johnson_18", 32'(johnson), 32'h3);
    cycle(1'b1);
    cycle(1'b1);
    check("sat_ignored_johnson", 32'(johnson), 32'h3);
    check("sat_ignored_cnt", 32'(cnt_flat), 32'h3f);
`ifdef DYN_PART_TRACE_EN
    check("sat_step_cnt", step_cnt, 32'd18);
`endif

    // sticky fixpoint: mode change is not sampled while blocked
    mode_sat = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1);
      check($sformatf("sticky_fix_%0d", i), 32'(fixpoint), 32'h1);
      check($sformatf("sticky_cnt_%0d", i), 32'(cnt_flat), 32'h3f);
      check($sformatf("sticky_wrap_%0d", i), 32'(wrap_pulse), 32'h0);
    end
    check("sticky_johnson", 32'(johnson), 32'h3);

    // stall: step_valid alternates, 4 of 8 cycles accepted
    do_reset();
    mode_sat = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle((i % 2) == 0);
      if ((i % 2) == 1) check($sformatf("stall_wrap_%0d", i), 32'(wrap_pulse), 32'h0);
    end
    check("stall_cnt", 32'(cnt_flat), 32'h12);
    check("stall_johnson", 32'(johnson), 32'h0);

    // reset mid-operation with a simultaneous step
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1);
    check("mid_cnt", 32'(cnt_flat), 32'h13);
    check("mid_johnson", 32'(johnson), 32'h1);
    rst        = 1'b1;
    step_valid = 1'b1;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    step_valid = 1'b0;
    check("midrst_cnt", 32'(cnt_flat), 32'h00);
    check("midrst_johnson", 32'(johnson), 32'h0);
    check("midrst_fixpoint", 32'(fixpoint), 32'h0);
    check("midrst_ready", 32'(step_ready), 32'h1);
`ifdef DYN_PART_TRACE_EN
    check("midrst_step_cnt", step_cnt, 32'd0);
`endif

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dyn_partition_counter.md
Name: dyn_partition_counter

Overview:
- Parametrised successor to the fixed two-partition, 3-bit phase-alternating counter transition system in the QBF fixpoint benchmark set.
- Holds NUM_PART counters of WIDTH bits. A NUM_PART-bit Johnson phase register selects which partition advances on each accepted step.
- Adds what the fixed model lacks: a step handshake, a wrap/saturate mode, wrap pulses and a sticky fixpoint detector.
- Used as the golden sequential model for generated dynamic-partition fixpoint benchmarks and their simulation cross-checks.

Parameters:
- NUM_PART, 2, number of partitions (>=2); also the Johnson register width.
- WIDTH, 3, bits per partition counter (>=1).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- step_valid  in  1  request one transition.
- step_ready  out  1  block can accept a transition.
- mode_sat  in  1  0 = wrap at 2^WIDTH-1, 1 = saturate at 2^WIDTH-1; sampled only on an accepted step.
- cnt_flat  out  NUM_PART*WIDTH  partition counters; partition p is at bits [p*WIDTH +: WIDTH].
- johnson  out  NUM_PART  phase register.
- active_idx  out  $clog2(NUM_PART)  partition that advances on the next accepted step.
- wrap_pulse  out  NUM_PART  one-cycle pulse when partition p wraps.
- fixpoint  out  1  sticky: state reached a fixpoint.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst).
- Reset values: all counters 0; johnson 0; wrap_pulse 0; fixpoint 0; step_ready 1; internal no-change counter 0.
- rst has priority over a simultaneous step. A step presented in the reset cycle is dropped.
- Accept: acc = step_valid & step_ready. step_ready = ~fixpoint (combinational from the register).
- Phase update on acc: johnson <= {johnson[NUM_PART-2:0], ~johnson[NUM_PART-1]}.
  - The register cycles through 2*NUM_PART states. State index k counts steps from reset (k = 0 at 0…0).
  - active_idx = k mod NUM_PART, decoded combinationally from johnson.
  - NUM_PART=2 sequence: 00->01->11->10->00, active 0,1,0,1.
- Counter update on acc: only partition a = active_idx changes. All other partitions hold.
  - mode_sat=0: cnt[a] <= cnt[a]+1 mod 2^WIDTH. When cnt[a] was all-ones, wrap_pulse[a]=1 in the following cycle.
  - mode_sat=1: if cnt[a] is all-ones it holds and no pulse is raised; else it increments.
- Latency: counter and johnson updates are visible the cycle after acc. wrap_pulse is registered and aligned with the counter update, high for exactly one cycle.
- No-change counter (width $clog2(2*NUM_PART+1)):
  - On acc with the counters unchanged, it increments. On acc with any change, it clears.
  - fixpoint sets on the acc that brings it to 2*NUM_PART (one full phase period with no counter change), visible next cycle.
- fixpoint is sticky until rst.
  - While fixpoint=1, step_ready=0: no steps accepted, nothing changes.
  - A mode_sat change while fixpoint=1 has no effect (it is not sampled).
- step_valid low: full hold; no pulses.
- Wrap mode never reaches fixpoint, since every step changes a counter.

Optional Feature:
- Macro: DYN_PART_TRACE_EN.
- Defined: adds output port step_cnt [31:0], reset 0, +1 per acc, wrapping at 2^32. Adds an assertion that active_idx < NUM_PART and johnson is a legal Johnson code.
- Undefined: no port, no counter, no assertions; all other behaviour identical.

Decomposition:
- Package dyn_partition_pkg holds:
  - function johnson_next(j)
  - function johnson_to_index(j) returning k
  - localparam helpers PHASES = 2*NUM_PART and the index widths
- One sub-module, dyn_partition_phase: Johnson register plus index decode. Inputs clk, rst, adv; outputs johnson, active_idx.
- Counters, pulses and fixpoint logic stay in the top level.

Test Plan (NUM_PART=2, WIDTH=3):
- Basic stepping: reset, mode_sat=0, 4 consecutive acc -> cnt0=2, cnt1=2, johnson=00, wrap_pulse never set.
- Wrap: mode_sat=0, 16 acc -> wrap_pulse[0] high for one cycle after step 15 and wrap_pulse[1] after step 16; final cnt0=cnt1=0, fixpoint=0.
- Saturate and fixpoint: mode_sat=1, 14 acc -> cnt0=cnt1=7. Steps 15-18 change nothing. fixpoint=1 and step_ready=0 the cycle after step 18. Further step_valid is ignored.
- Stall: alternate step_valid 1/0 for 8 cycles -> exactly 4 transitions, johnson=00, cnt0=cnt1=2.
- Reset mid-operation: after 5 steps (cnt0=3, cnt1=2), assert rst with step_valid=1 -> next cycle all counters 0, johnson=00, fixpoint=0, step_ready=1.
- Sticky fixpoint: from fixpoint=1, toggle mode_sat to 0 and drive step_valid for 3 cycles -> fixpoint stays 1, counters stay 7/7, no wrap_pulse.
